// File: rtl/down_counter_ctrl.sv
// Down counter driven by rising edges of the 1 Hz divider output, with start/pause/load control.
// Optional SEG7_OUT_EN adds a registered active-low seven-segment decode of the count.
module down_counter_ctrl #(
   parameter int                 WIDTH       = 4,
   parameter logic [WIDTH-1:0]   RESET_VAL   = 4'hF,
   parameter int                 AUTO_RELOAD = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick_in,
   input  logic             start,
   input  logic             pause,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             running,
   output logic             zero,
   output logic             done,
   output logic [1:0]       state_dbg
`ifdef SEG7_OUT_EN
   ,
   output logic [6:0]       seg
`endif
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             running_q, running_d;
   logic             done_q, done_d;
   logic             tick_q;
   logic             tick_rise;

   // tick_q resets high so a divider output already high at reset release is not an edge
   assign tick_rise = tick_in & ~tick_q;

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      done_d   = 1'b0;
      if (load) begin
         count_d  = load_val;
         reload_d = load_val;
         state_d  = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start && (count_q != '0)) state_d = RUN;
            end
            RUN: begin
               if (pause) begin
                  state_d = PAUSED;
               end else if (!start && tick_rise) begin
                  if (count_q > WIDTH'(1)) begin
                     count_d = count_q - WIDTH'(1);
                  end else if (count_q == WIDTH'(1)) begin
                     count_d = '0;
                     done_d  = 1'b1;
                     if (AUTO_RELOAD == 0) state_d = DONE;
                  end else begin
                     count_d = reload_q;
                  end
               end
            end
            PAUSED: begin
               if (!pause && start) state_d = RUN;
            end
            DONE: begin
               if (start && (reload_q != '0)) begin
                  count_d = reload_q;
                  state_d = RUN;
               end
            end
            default: state_d = IDLE;
         endcase
      end
      running_d = (state_d == RUN);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         count_q   <= RESET_VAL;
         reload_q  <= RESET_VAL;
         running_q <= 1'b0;
         done_q    <= 1'b0;
         tick_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         reload_q  <= reload_d;
         running_q <= running_d;
         done_q    <= done_d;
         tick_q    <= tick_in;
      end
   end

   assign count     = count_q;
   assign running   = running_q;
   assign done      = done_q;
   assign zero      = (count_q == '0);
   assign state_dbg = state_q;

`ifdef SEG7_OUT_EN
   // Segment order {g,f,e,d,c,b,a}, active-low
   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: hex7 = 7'b1000000;
         4'h1: hex7 = 7'b1111001;
         4'h2: hex7 = 7'b0100100;
         4'h3: hex7 = 7'b0110000;
         4'h4: hex7 = 7'b0011001;
         4'h5: hex7 = 7'b0010010;
         4'h6: hex7 = 7'b0000010;
         4'h7: hex7 = 7'b1111000;
         4'h8: hex7 = 7'b0000000;
         4'h9: hex7 = 7'b0010000;
         4'hA: hex7 = 7'b0001000;
         4'hB: hex7 = 7'b0000011;
         4'hC: hex7 = 7'b1000110;
         4'hD: hex7 = 7'b0100001;
         4'hE: hex7 = 7'b0000110;
         default: hex7 = 7'b0001110;
      endcase
   endfunction

   logic [6:0] seg_q;

   always_ff @(posedge clk) begin
      if (reset) seg_q <= hex7(4'(RESET_VAL));
      else       seg_q <= hex7(4'(count_q));
   end

   assign seg = seg_q;
`endif

endmodule
